hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have inputs id_valid (1), id_rs1/id_rs2 (5 each), id_use_rs1/id_use_rs2 (1 each) and id_is_branch (1): the ID-stage instruction and which sources it reads.
REQ-004 SHALL have inputs ex_rd (5), ex_reg_write (1) and ex_is_load (1): the instruction in EX.
REQ-005 SHALL have inputs mem_rd (5), mem_reg_write (1) and mem_is_load (1): the instruction in MEM.
REQ-006 SHALL have inputs i_prediction (1) and i_boj (1): the fetch prediction and the ID branch/jump decision.
REQ-007 SHALL have input i_ex_stall (1): multi-cycle EX operation freeze.
REQ-008 SHALL have outputs o_stall (1), o_bubble_ex (1), o_flush (1) and o_kill_id (1): pipeline control.
REQ-009 SHALL have outputs o_decode_forward_rs1, o_decode_forward_rs2 and o_forward_branch (1 each): select the EX result into the ID branch comparator.
REQ-010 SHALL have outputs o_stall_cnt and o_flush_cnt (16 each): performance counters.

Function
REQ-011 SHALL define match_s(x) = id_valid & id_use_s & (x_rd != 0) & (x_rd == id_rs_s), where x is the EX or MEM producer, with its reg_write qualified.
REQ-012 SHALL raise hazard length N=1 on load-use: match on the EX producer with ex_is_load, for any instruction.
REQ-013 SHALL raise N=2 when id_is_branch matches the EX producer with ex_is_load.
REQ-014 SHALL raise N=1 when id_is_branch matches the MEM producer with mem_is_load; the maximum N wins when several apply.
REQ-015 SHALL drive, combinationally, o_forward_branch=1 and o_decode_forward_rs1/rs2=1 for each source that has an id_is_branch match on a non-load EX producer; this SHALL cause no stall.
REQ-016 SHALL implement an FSM with states RUN, HOLD and FLUSH.
REQ-017 SHALL, in RUN with hazard N>=1, assert o_stall=1 and o_bubble_ex=1 this cycle, moving to HOLD if N=2 and staying in RUN if N=1.
REQ-018 SHALL, in HOLD, assert o_stall=1 and o_bubble_ex=1 and go to RUN; hazard detection SHALL be ignored in HOLD.
REQ-019 SHALL, in RUN with no hazard, id_valid=1 and (i_prediction ^ i_boj)=1, assert o_flush=1 for exactly this cycle and go to FLUSH.
REQ-020 SHALL, in FLUSH, assert o_kill_id=1 for one cycle (ID holds a wrong-path instruction), suppress hazard, flush and forward outputs, and go to RUN.
REQ-021 SHALL give priority i_ex_stall > hazard > flush: i_ex_stall=1 forces o_stall=1 and o_bubble_ex=0, holds state, holds the counters and blocks o_flush.
REQ-022 SHALL hold state in HOLD or FLUSH unchanged and unconsumed while i_ex_stall=1.
REQ-023 SHALL increment o_stall_cnt by 1 in each cycle with o_stall=1 caused by a hazard (not by i_ex_stall), saturating at 16'hFFFF.
REQ-024 SHALL increment o_flush_cnt by 1 on each o_flush pulse, saturating at 16'hFFFF.
REQ-025 SHALL make all control outputs combinational from state and inputs, with zero-cycle latency; only state and counters are registered.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state=RUN and o_stall_cnt=o_flush_cnt=0.
REQ-027 SHALL force o_stall, o_bubble_ex, o_flush, o_kill_id and all forward selects to 0 while rst=1.
REQ-028 SHALL abandon HOLD or FLUSH on reset mid-operation with no residual stall or kill.

Verification
REQ-029 SHALL cover: EX lw x5 with ID add x6,x5,x1 -> o_stall=o_bubble_ex=1 for 1 cycle, stall_cnt=1.
REQ-030 SHALL cover: EX lw x5 with ID beq x5,x0 -> o_stall=1 for 2 consecutive cycles (RUN->HOLD->RUN), stall_cnt=2.
REQ-031 SHALL cover: EX add x7 with ID bne x7,x2 -> o_forward_branch=1, o_decode_forward_rs1=1, o_decode_forward_rs2=0, o_stall=0.
REQ-032 SHALL cover: producer rd=x0 with ID reading x0 -> no stall and no forward.
REQ-033 SHALL cover: i_prediction=0, i_boj=1 -> o_flush=1 for 1 cycle, o_kill_id=1 the next cycle, flush_cnt=1; the same with i_ex_stall=1 -> no flush until the stall drops.
REQ-034 SHALL cover: rst=1 asserted during HOLD -> next cycle state=RUN, all outputs 0, counters 0; counters preset to 16'hFFFF stay at 16'hFFFF on a further stall or flush.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, ID-stage branch forwarding,
// misprediction flush with wrong-path kill, and saturating stall/flush performance counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_is_branch,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_is_load,
  input  logic        i_prediction,
  input  logic        i_boj,
  input  logic        i_ex_stall,
  output logic        o_stall,
  output logic        o_bubble_ex,
  output logic        o_flush,
  output logic        o_kill_id,
  output logic        o_decode_forward_rs1,
  output logic        o_decode_forward_rs2,
  output logic        o_forward_branch,
  output logic [15:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
);

  typedef enum logic [1:0] {StRun, StHold, StFlush} state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic ex_load_hit, mem_load_hit, haz_any, haz_two, mispredict;

  assign ex_m1  = id_valid & id_use_rs1 & ex_reg_write  & (ex_rd  != 5'd0) & (ex_rd  == id_rs1);
  assign ex_m2  = id_valid & id_use_rs2 & ex_reg_write  & (ex_rd  != 5'd0) & (ex_rd  == id_rs2);
  assign mem_m1 = id_valid & id_use_rs1 & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == id_rs1);
  assign mem_m2 = id_valid & id_use_rs2 & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == id_rs2);

  assign ex_load_hit  = ex_is_load & (ex_m1 | ex_m2);
  assign mem_load_hit = mem_is_load & (mem_m1 | mem_m2);
  // A branch behind a load in EX needs the value two cycles later; otherwise one cycle.
  assign haz_two      = id_is_branch & ex_load_hit;
  assign haz_any      = ex_load_hit | (id_is_branch & mem_load_hit);
  assign mispredict   = id_valid & (i_prediction ^ i_boj);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!i_ex_stall) begin
      unique case (state_q)
        StRun: begin
          if (haz_two) begin
            state_d = StHold;
          end else if (!haz_any && mispredict) begin
            state_d = StFlush;
          end
        end
        StHold:  state_d = StRun;
        StFlush: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
    // Only hazard stalls count; an EX freeze holds both counters.
    if (o_stall && !i_ex_stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (o_flush && flush_cnt_q != 16'hFFFF) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_comb begin
    o_stall              = 1'b0;
    o_bubble_ex          = 1'b0;
    o_flush              = 1'b0;
    o_kill_id            = 1'b0;
    o_decode_forward_rs1 = 1'b0;
    o_decode_forward_rs2 = 1'b0;
    o_forward_branch     = 1'b0;
    if (!rst) begin
      if (i_ex_stall) begin
        o_stall = 1'b1;
      end else begin
        unique case (state_q)
          StRun: begin
            if (haz_any) begin
              o_stall     = 1'b1;
              o_bubble_ex = 1'b1;
            end else if (mispredict) begin
              o_flush = 1'b1;
            end
          end
          StHold: begin
            o_stall     = 1'b1;
            o_bubble_ex = 1'b1;
          end
          StFlush: o_kill_id = 1'b1;
          default: ;
        endcase
      end
      // ID holds a wrong-path instruction while in StFlush, so it must not steer forwarding.
      if (state_q != StFlush) begin
        o_decode_forward_rs1 = id_is_branch & ex_m1 & ~ex_is_load;
        o_decode_forward_rs2 = id_is_branch & ex_m2 & ~ex_is_load;
        o_forward_branch     = o_decode_forward_rs1 | o_decode_forward_rs2;
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random traffic,
// all checked every cycle against a cycle-count model of owed stalls and pending kills.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_is_branch;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        ex_reg_write, ex_is_load, mem_reg_write, mem_is_load;
  logic        i_prediction, i_boj, i_ex_stall;
  logic        o_stall, o_bubble_ex, o_flush, o_kill_id;
  logic        o_decode_forward_rs1, o_decode_forward_rs2, o_forward_branch;
  logic [15:0] o_stall_cnt, o_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_valid             (id_valid),
    .id_rs1               (id_rs1),
    .id_rs2               (id_rs2),
    .id_use_rs1           (id_use_rs1),
    .id_use_rs2           (id_use_rs2),
    .id_is_branch         (id_is_branch),
    .ex_rd                (ex_rd),
    .ex_reg_write         (ex_reg_write),
    .ex_is_load           (ex_is_load),
    .mem_rd               (mem_rd),
    .mem_reg_write        (mem_reg_write),
    .mem_is_load          (mem_is_load),
    .i_prediction         (i_prediction),
    .i_boj                (i_boj),
    .i_ex_stall           (i_ex_stall),
    .o_stall              (o_stall),
    .o_bubble_ex          (o_bubble_ex),
    .o_flush              (o_flush),
    .o_kill_id            (o_kill_id),
    .o_decode_forward_rs1 (o_decode_forward_rs1),
    .o_decode_forward_rs2 (o_decode_forward_rs2),
    .o_forward_branch     (o_forward_branch),
    .o_stall_cnt          (o_stall_cnt),
    .o_flush_cnt          (o_flush_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: stalls still owed after this cycle, a pending wrong-path kill, and event totals.
  int m_owed   = 0;
  bit m_kill   = 1'b0;
  int m_scnt   = 0;
  int m_fcnt   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] rd, input logic wr, input logic [4:0] rs,
                               input logic use_s);
    return id_valid && use_s && wr && rd != 5'd0 && rd == rs;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      bit ex1, ex2, mem1, mem2, e_stall, e_bub, e_fl, e_kill, e_f1, e_f2;
      int need;
      ex1  = reads(ex_rd, ex_reg_write, id_rs1, id_use_rs1);
      ex2  = reads(ex_rd, ex_reg_write, id_rs2, id_use_rs2);
      mem1 = reads(mem_rd, mem_reg_write, id_rs1, id_use_rs1);
      mem2 = reads(mem_rd, mem_reg_write, id_rs2, id_use_rs2);
      need = 0;
      if (ex_is_load && (ex1 || ex2)) need = id_is_branch ? 2 : 1;
      else if (mem_is_load && (mem1 || mem2) && id_is_branch) need = 1;
      e_stall = 0; e_bub = 0; e_fl = 0; e_kill = 0; e_f1 = 0; e_f2 = 0;
      if (!rst) begin
        if (!m_kill && id_is_branch && !ex_is_load) begin
          e_f1 = ex1;
          e_f2 = ex2;
        end
        if (i_ex_stall) e_stall = 1;
        else if (m_owed > 0) begin e_stall = 1; e_bub = 1; end
        else if (m_kill) e_kill = 1;
        else if (need > 0) begin e_stall = 1; e_bub = 1; end
        else if (id_valid && (i_prediction != i_boj)) e_fl = 1;
      end
      check("stall", 16'(o_stall), 16'(e_stall));
      check("bubble_ex", 16'(o_bubble_ex), 16'(e_bub));
      check("flush", 16'(o_flush), 16'(e_fl));
      check("kill_id", 16'(o_kill_id), 16'(e_kill));
      check("fwd_rs1", 16'(o_decode_forward_rs1), 16'(e_f1));
      check("fwd_rs2", 16'(o_decode_forward_rs2), 16'(e_f2));
      check("fwd_branch", 16'(o_forward_branch), 16'(e_f1 | e_f2));
      check("stall_cnt", o_stall_cnt, 16'(m_scnt));
      check("flush_cnt", o_flush_cnt, 16'(m_fcnt));
      if (rst) begin
        m_owed = 0; m_kill = 0; m_scnt = 0; m_fcnt = 0;
      end else if (!i_ex_stall) begin
        if (m_owed > 0) begin m_owed--; m_scnt = sat_inc(m_scnt); end
        else if (m_kill) m_kill = 0;
        else if (need > 0) begin m_owed = need - 1; m_scnt = sat_inc(m_scnt); end
        else if (e_fl) begin m_kill = 1; m_fcnt = sat_inc(m_fcnt); end
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_branch = 0;
    ex_rd = 0; ex_reg_write = 0; ex_is_load = 0;
    mem_rd = 0; mem_reg_write = 0; mem_is_load = 0;
    i_prediction = 0; i_boj = 0; i_ex_stall = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic id_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic br);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = 1; id_use_rs2 = 1; id_is_branch = br;
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    chk_en = 1;

    // lw x5 in EX, add x6,x5,x1 in ID: one stall cycle
    do_reset();
    ex_rd = 5; ex_reg_write = 1; ex_is_load = 1; id_instr(5, 1, 0);
    @(negedge clk);
    check("lu_stall", 16'(o_stall), 16'd1);
    check("lu_bubble", 16'(o_bubble_ex), 16'd1);
    step(); idle();
    @(negedge clk);
    check("lu_release", 16'(o_stall), 16'd0);
    check("lu_cnt", o_stall_cnt, 16'd1);

    // lw x5 in EX, beq x5,x0 in ID: two stall cycles
    do_reset();
    ex_rd = 5; ex_reg_write = 1; ex_is_load = 1; id_instr(5, 0, 1);
    @(negedge clk);
    check("br_stall1", 16'(o_stall), 16'd1);
    step();
    ex_rd = 0; ex_reg_write = 0; ex_is_load = 0; mem_rd = 5; mem_reg_write = 1; mem_is_load = 1;
    @(negedge clk);
    check("br_stall2", 16'(o_stall), 16'd1);
    step();
    mem_rd = 0; mem_reg_write = 0; mem_is_load = 0;
    @(negedge clk);
    check("br_release", 16'(o_stall), 16'd0);
    check("br_cnt", o_stall_cnt, 16'd2);

    // add x7 in EX, bne x7,x2 in ID: forward rs1 only, no stall
    do_reset();
    ex_rd = 7; ex_reg_write = 1; id_instr(7, 2, 1);
    @(negedge clk);
    check("fw_branch", 16'(o_forward_branch), 16'd1);
    check("fw_rs1", 16'(o_decode_forward_rs1), 16'd1);
    check("fw_rs2", 16'(o_decode_forward_rs2), 16'd0);
    check("fw_nostall", 16'(o_stall), 16'd0);

    // producer x0: neither stall nor forward
    step();
    ex_rd = 0; ex_reg_write = 1; ex_is_load = 1; id_instr(0, 0, 1);
    @(negedge clk);
    check("x0_stall", 16'(o_stall), 16'd0);
    check("x0_fwd", 16'(o_forward_branch), 16'd0);

    // misprediction: flush, then kill
    do_reset();
    id_valid = 1; i_prediction = 0; i_boj = 1;
    @(negedge clk);
    check("mp_flush", 16'(o_flush), 16'd1);
    step(); idle();
    @(negedge clk);
    check("mp_kill", 16'(o_kill_id), 16'd1);
    check("mp_noflush", 16'(o_flush), 16'd0);
    check("mp_cnt", o_flush_cnt, 16'd1);
    step();
    @(negedge clk);
    check("mp_kill_done", 16'(o_kill_id), 16'd0);

    // misprediction under EX freeze waits for the freeze to drop
    id_valid = 1; i_prediction = 0; i_boj = 1; i_ex_stall = 1;
    @(negedge clk);
    check("xs_noflush", 16'(o_flush), 16'd0);
    check("xs_stall", 16'(o_stall), 16'd1);
    step();
    @(negedge clk);
    check("xs_noflush2", 16'(o_flush), 16'd0);
    check("xs_cnt_held", o_stall_cnt, 16'd0);
    step();
    i_ex_stall = 0;
    @(negedge clk);
    check("xs_flush", 16'(o_flush), 16'd1);
    step(); idle();
    @(negedge clk);
    check("xs_kill", 16'(o_kill_id), 16'd1);
    check("xs_fcnt", o_flush_cnt, 16'd2);

    // reset during the second cycle of a branch stall
    do_reset();
    ex_rd = 5; ex_reg_write = 1; ex_is_load = 1; id_instr(5, 0, 1);
    @(negedge clk);
    check("rh_stall", 16'(o_stall), 16'd1);
    step();
    rst = 1;
    @(negedge clk);
    check("rh_rst_stall", 16'(o_stall), 16'd0);
    check("rh_rst_bubble", 16'(o_bubble_ex), 16'd0);
    step();
    rst = 0; idle();
    @(negedge clk);
    check("rh_after_stall", 16'(o_stall), 16'd0);
    check("rh_after_kill", 16'(o_kill_id), 16'd0);
    check("rh_after_cnt", o_stall_cnt, 16'd0);

    // counters preset to all-ones saturate
    step();
    force dut.stall_cnt_q = 16'hFFFF;
    force dut.flush_cnt_q = 16'hFFFF;
    m_scnt = 65535;
    m_fcnt = 65535;
    ex_rd = 5; ex_reg_write = 1; ex_is_load = 1; id_instr(5, 1, 0);
    @(negedge clk);
    #1;
    release dut.stall_cnt_q;
    release dut.flush_cnt_q;
    step();
    idle(); id_valid = 1; i_prediction = 1; i_boj = 0;
    @(negedge clk);
    check("sat_stall_cnt", o_stall_cnt, 16'hFFFF);
    check("sat_flush_pulse", 16'(o_flush), 16'd1);
    step(); idle();
    @(negedge clk);
    check("sat_flush_cnt", o_flush_cnt, 16'hFFFF);

    // random traffic with a narrow register range so dependences are frequent
    for (int i = 0; i < 3000; i++) begin
      step();
      rst           = ($urandom_range(0, 63) == 0);
      id_valid      = ($urandom_range(0, 7) != 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom);
      id_use_rs2    = 1'($urandom);
      id_is_branch  = 1'($urandom);
      ex_rd         = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom);
      ex_is_load    = 1'($urandom);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom);
      mem_is_load   = 1'($urandom);
      i_prediction  = 1'($urandom);
      i_boj         = ($urandom_range(0, 3) == 0) ? ~i_prediction : i_prediction;
      i_ex_stall    = ($urandom_range(0, 6) == 0);
    end
    step();
    idle();
    @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
